regw_arbiter: RTL and testbench

REGW_ARBITER -- requirements
Module: regw_arbiter

---
 rtl/regw_arbiter_if.sv | 39 +++
 rtl/regw_arbiter.sv | 65 ++++++
 tb/tb_regw_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regw_arbiter_if.sv
// Register-file write bus shared by the two writeback requesters and
// the regw_arbiter. Requesters sit on the master modport and the
// arbiter on the slave modport.

`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif

interface regw_arbiter_if;
    logic              req0_valid;
    logic [`RegAddrBus] req0_addr;
    logic [`RegBus]     req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [`RegAddrBus] req1_addr;
    logic [`RegBus]     req1_data;
    logic              req1_ready;
    logic              write;
    logic [`RegAddrBus] regw_addr;
    logic [`RegBus]     regw_data;
    logic              grant_last;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  write, regw_addr, regw_data, grant_last
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output write, regw_addr, regw_data, grant_last
    );
endinterface

// File: rtl/regw_arbiter.sv
// Two-requester register-file write arbiter (ALU writeback vs load
// writeback). Round-robin by default; defining REGW_ARB_FIXED_PRIO_EN
// makes requester 0 always win contention. Ready is combinational and
// depends only on valids, reset and the registered last-grant index.
// Accepted writes appear on the registered write port one cycle later;
// writes to x0 are accepted but never raise the write enable.

module regw_arbiter (
    input  logic           clock,
    input  logic           reset,
    regw_arbiter_if.slave  bus
);

    logic               w_grant0;
    logic               w_grant1;
    logic               r_write;
    logic [`RegAddrBus] r_regwAddr;
    logic [`RegBus]     r_regwData;
    logic               r_grantLast;

    // Grant decision: at most one requester accepted, none during reset
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
`ifdef REGW_ARB_FIXED_PRIO_EN
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid && !bus.req0_valid;
`else
            w_grant0 = bus.req0_valid && (!bus.req1_valid || r_grantLast);
            w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_grantLast);
`endif
        end
    end

    // Output register and last-grant tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_regwAddr  <= '0;
            r_regwData  <= '0;
            r_grantLast <= 1'b1;
        end else if (w_grant0) begin
            r_write     <= (bus.req0_addr != '0);
            r_regwAddr  <= bus.req0_addr;
            r_regwData  <= bus.req0_data;
            r_grantLast <= 1'b0;
        end else if (w_grant1) begin
            r_write     <= (bus.req1_addr != '0);
            r_regwAddr  <= bus.req1_addr;
            r_regwData  <= bus.req1_data;
            r_grantLast <= 1'b1;
        end else begin
            r_write     <= 1'b0;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.write      = r_write;
    assign bus.regw_addr  = r_regwAddr;
    assign bus.regw_data  = r_regwData;
    assign bus.grant_last = r_grantLast;

endmodule

// File: tb/tb_regw_arbiter.sv
// Directed bench for regw_arbiter. Inputs change on the falling edge;
// ready is checked shortly after, and registered outputs are checked on
// the falling edge following the rising edge that loaded them.
// Build with REGW_ARB_FIXED_PRIO_EN defined to exercise fixed priority.

module tb_regw_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    regw_arbiter_if bus ();

    regw_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    task automatic checkReady(input string tag, input logic r0, input logic r1);
        #1;
        checkOutput({tag, "_rdy0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
        checkOutput({tag, "_rdy1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    endtask

    task automatic checkRegs(input string tag, input logic w, input logic [4:0] a,
                             input logic [31:0] d, input logic g);
        checkOutput({tag, "_write"}, {31'd0, bus.write}, {31'd0, w});
        checkOutput({tag, "_addr"},  {27'd0, bus.regw_addr}, {27'd0, a});
        checkOutput({tag, "_data"},  bus.regw_data, d);
        checkOutput({tag, "_glast"}, {31'd0, bus.grant_last}, {31'd0, g});
    endtask

    // Linear directed sequence
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);

        // Reset state, ready suppressed while reset is high
        nextCycle();
        nextCycle();
        checkReady("rst", 1'b0, 1'b0);
        checkRegs("rst", 1'b0, 5'd0, 32'h0, 1'b1);

        // Single requester
        reset = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        checkReady("single", 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkRegs("single_t1", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        checkReady("idle", 1'b0, 1'b0);
        nextCycle();
        checkRegs("single_t2", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);

        // Re-reset so requester 0 wins the next contention
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkRegs("rerst", 1'b0, 5'd0, 32'h0, 1'b1);

`ifdef REGW_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 wins every contention
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        for (int i = 0; i < 3; i++) begin
            checkReady("fix", 1'b1, 1'b0);
            nextCycle();
            checkRegs("fix_out", 1'b1, 5'd3, 32'h11, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h22);
        checkReady("fix_r1", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkRegs("fix_r1_out", 1'b1, 5'd4, 32'h22, 1'b1);
        nextCycle();
`else
        // Round-robin contention: 0,1,0,1 with consecutive writes
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        checkReady("rr1", 1'b1, 1'b0);
        nextCycle();
        checkRegs("rr1_out", 1'b1, 5'd3, 32'h11, 1'b0);
        applyStimulus(1'b1, 5'd6, 32'h33, 1'b1, 5'd4, 32'h22);
        checkReady("rr2", 1'b0, 1'b1);
        nextCycle();
        checkRegs("rr2_out", 1'b1, 5'd4, 32'h22, 1'b1);
        applyStimulus(1'b1, 5'd6, 32'h33, 1'b1, 5'd7, 32'h44);
        checkReady("rr3", 1'b1, 1'b0);
        nextCycle();
        checkRegs("rr3_out", 1'b1, 5'd6, 32'h33, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h44);
        checkReady("rr4", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkRegs("rr4_out", 1'b1, 5'd7, 32'h44, 1'b1);
        nextCycle();
`endif

        // x0 write accepted but not issued; requester 1 last granted
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        checkReady("x0", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkRegs("x0_out", 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1);

        // Same-address contention: both writes issue, in grant order
        applyStimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        checkReady("same1", 1'b1, 1'b0);
        nextCycle();
        checkRegs("same1_out", 1'b1, 5'd9, 32'hA, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB);
        checkReady("same2", 1'b0, 1'b1);
        nextCycle();
        checkRegs("same2_out", 1'b1, 5'd9, 32'hB, 1'b1);

        // Reset mid-stream with both valid throughout
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        checkReady("mid_pre", 1'b1, 1'b0);
        nextCycle();
        checkRegs("mid_pre_out", 1'b1, 5'd1, 32'h100, 1'b0);
        reset = 1'b1;
        checkReady("mid_rst1", 1'b0, 1'b0);
        nextCycle();
        checkRegs("mid_rst1_out", 1'b0, 5'd0, 32'h0, 1'b1);
        checkReady("mid_rst2", 1'b0, 1'b0);
        nextCycle();
        checkRegs("mid_rst2_out", 1'b0, 5'd0, 32'h0, 1'b1);
        reset = 1'b0;
        checkReady("mid_post", 1'b1, 1'b0);
        nextCycle();
        checkRegs("mid_post_out", 1'b1, 5'd1, 32'h100, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        nextCycle();
        checkRegs("end_idle", 1'b0, 5'd1, 32'h100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
